// File: rtl/fifoctl_s1_dyn_pkg.sv
// fifoctl_pkg: shared types and helper functions for the fifoctl family.
//   clog2      - ceiling log2 used to size address and count vectors
//   err_mode_e - error reporting mode (sticky or one-cycle pulse)
//   flags_t    - packed status flag vector produced by fifoctl_flag_gen
//   wrap_inc   - pointer increment that wraps at an arbitrary depth
package fifoctl_pkg;

    typedef enum logic [0:0] {
        ERR_STICKY = 1'b0,
        ERR_PULSE  = 1'b1
    } err_mode_e;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic half_full;
        logic almost_full;
        logic full;
    } flags_t;

    // Smallest r with 2**r >= n.
    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            r = ((32'sd1 <<< i) < n) ? (i + 32'sd1) : r;
        end
        return r;
    endfunction

    // Increment with an explicit wrap at depth-1, so non power-of-two
    // depths never reach the unused upper addresses.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        int unsigned nxt;
        if (ptr >= (depth - 32'd1)) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fifoctl_s1_dyn_if.sv
// fifoctl_s1_dyn_if: request, threshold and status bundle of the FIFO controller.
//   master: producer/consumer side (drives requests and levels, observes status)
//   slave : controller side (observes requests, drives RAM controls and status)
//   Signals: push_req_n, pop_req_n, ae_level, af_level, we_n, wr_addr, rd_addr,
//            word_count, empty, almost_empty, half_full, almost_full, full, error.
interface fifoctl_s1_dyn_if
    import fifoctl_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic          push_req_n;
    logic          pop_req_n;
    logic [CW-1:0] ae_level;
    logic [CW-1:0] af_level;
    logic          we_n;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] word_count;
    logic          empty;
    logic          almost_empty;
    logic          half_full;
    logic          almost_full;
    logic          full;
    logic          error;

    modport master (
        output push_req_n, pop_req_n, ae_level, af_level,
        input  we_n, wr_addr, rd_addr, word_count,
        input  empty, almost_empty, half_full, almost_full, full, error
    );

    modport slave (
        input  push_req_n, pop_req_n, ae_level, af_level,
        output we_n, wr_addr, rd_addr, word_count,
        output empty, almost_empty, half_full, almost_full, full, error
    );

endinterface

// File: rtl/fifoctl_s1_dyn_flag_gen.sv
// fifoctl_flag_gen: registered status flags derived from the next occupancy.
//   clk, rst_n  - clock and asynchronous active-low reset
//   next_count  - occupancy the FIFO will hold after the coming edge
//   ae_level    - almost-empty threshold (empty-ish when count <= ae_level)
//   af_level    - almost-full distance (full-ish when count >= DEPTH - af_level)
//   flags       - registered flag vector
// Kept free of pointer logic so the dual-clock variant can reuse it.
module fifoctl_flag_gen
    import fifoctl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] next_count,
    input  logic [CW-1:0] ae_level,
    input  logic [CW-1:0] af_level,
    output flags_t        flags
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] HALF_C  = CW'((DEPTH + 32'sd1) / 32'sd2);

    logic [CW-1:0] af_thr_s;
    flags_t        flags_s;
    flags_t        rst_flags_s;
    flags_t        flags_r;

    // Almost-full threshold, clamped at zero when af_level reaches the depth.
    always_comb begin
        if (af_level >= DEPTH_C) begin
            af_thr_s = '0;
        end else begin
            af_thr_s = DEPTH_C - af_level;
        end
    end

    // Flags for the occupancy after this edge, plus the empty-FIFO reset image.
    always_comb begin
        flags_s                  = '0;
        flags_s.empty            = (next_count == '0);
        flags_s.almost_empty     = (next_count <= ae_level);
        flags_s.half_full        = (next_count >= HALF_C);
        flags_s.almost_full      = (next_count >= af_thr_s);
        flags_s.full             = (next_count == DEPTH_C);
        rst_flags_s              = '0;
        rst_flags_s.empty        = 1'b1;
        rst_flags_s.almost_empty = 1'b1;
        rst_flags_s.almost_full  = (af_thr_s == '0);
    end

    // Flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= rst_flags_s;
        end else begin
            flags_r <= flags_s;
        end
    end

    assign flags = flags_r;

endmodule

// File: rtl/fifoctl_s1_dyn.sv
// fifoctl_s1_dyn: single-clock FIFO controller for an external 1W/1R RAM.
//   DEPTH    - 2..256 words, any value (pointers wrap by compare)
//   ERR_MODE - 0: sticky error, 1: one-cycle error pulse per bad request
//   clk, rst_n - clock and asynchronous active-low reset
//   diag_n     - active-low synchronous clear; only when the macro
//                FIFOCTL_S1_DYN_DIAG_EN is defined
//   bus (slave) - requests, levels, we_n (combinational), registered
//                 addresses, word count, status flags and error
module fifoctl_s1_dyn
    import fifoctl_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ERR_MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef FIFOCTL_S1_DYN_DIAG_EN
    input  logic            diag_n,
`endif
    fifoctl_s1_dyn_if.slave bus
);
    localparam int              AW         = clog2(DEPTH);
    localparam int              CW         = clog2(DEPTH + 32'sd1);
    localparam int unsigned     DEPTH_U    = DEPTH;
    localparam err_mode_e       ERR_MODE_E = (ERR_MODE != 32'sd0) ? ERR_PULSE : ERR_STICKY;
    localparam logic [CW-1:0]   ONE_C      = CW'(32'd1);

    logic          clr_s;
    logic          push_a_s;
    logic          pop_a_s;
    logic          err_evt_s;
    logic          error_nxt_s;
    logic          error_r;
    logic [AW-1:0] wr_addr_nxt_s;
    logic [AW-1:0] rd_addr_nxt_s;
    logic [AW-1:0] wr_addr_r;
    logic [AW-1:0] rd_addr_r;
    logic [CW-1:0] next_count_s;
    logic [CW-1:0] count_r;
    flags_t        flags_r;

`ifdef FIFOCTL_S1_DYN_DIAG_EN
    assign clr_s = ~diag_n;
`else
    assign clr_s = 1'b0;
`endif

    // Request acceptance and error events. A push into a full FIFO is only
    // taken alongside a pop; a pop from an empty FIFO is never taken.
    always_comb begin
        push_a_s  = ~bus.push_req_n & (~flags_r.full | ~bus.pop_req_n) & ~clr_s;
        pop_a_s   = ~bus.pop_req_n & ~flags_r.empty & ~clr_s;
        err_evt_s = (~bus.push_req_n & flags_r.full & bus.pop_req_n)
                  | (~bus.pop_req_n & flags_r.empty);
    end

    // Next occupancy, pointers and error state.
    always_comb begin
        next_count_s  = count_r;
        wr_addr_nxt_s = wr_addr_r;
        rd_addr_nxt_s = rd_addr_r;
        error_nxt_s   = error_r;
        if (clr_s) begin
            next_count_s  = '0;
            wr_addr_nxt_s = '0;
            rd_addr_nxt_s = '0;
            error_nxt_s   = 1'b0;
        end else begin
            case ({push_a_s, pop_a_s})
                2'b10:   next_count_s = count_r + ONE_C;
                2'b01:   next_count_s = count_r - ONE_C;
                default: next_count_s = count_r;
            endcase
            if (push_a_s) begin
                wr_addr_nxt_s = AW'(wrap_inc(32'(wr_addr_r), DEPTH_U));
            end else begin
                wr_addr_nxt_s = wr_addr_r;
            end
            if (pop_a_s) begin
                rd_addr_nxt_s = AW'(wrap_inc(32'(rd_addr_r), DEPTH_U));
            end else begin
                rd_addr_nxt_s = rd_addr_r;
            end
            if (ERR_MODE_E == ERR_PULSE) begin
                error_nxt_s = err_evt_s;
            end else begin
                error_nxt_s = error_r | err_evt_s;
            end
        end
    end

    // Pointer, count and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_r <= '0;
            rd_addr_r <= '0;
            count_r   <= '0;
            error_r   <= 1'b0;
        end else begin
            wr_addr_r <= wr_addr_nxt_s;
            rd_addr_r <= rd_addr_nxt_s;
            count_r   <= next_count_s;
            error_r   <= error_nxt_s;
        end
    end

    fifoctl_flag_gen #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_flag_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_count (next_count_s),
        .ae_level   (bus.ae_level),
        .af_level   (bus.af_level),
        .flags      (flags_r)
    );

    assign bus.we_n         = ~push_a_s;
    assign bus.wr_addr      = wr_addr_r;
    assign bus.rd_addr      = rd_addr_r;
    assign bus.word_count   = count_r;
    assign bus.empty        = flags_r.empty;
    assign bus.almost_empty = flags_r.almost_empty;
    assign bus.half_full    = flags_r.half_full;
    assign bus.almost_full  = flags_r.almost_full;
    assign bus.full         = flags_r.full;
    assign bus.error        = error_r;

endmodule

// File: tb/tb_fifoctl_s1_dyn.sv
// Bench for fifoctl_s1_dyn: a DEPTH=4 sticky-error instance and a DEPTH=5
// pulse-error instance share one stimulus stream. A model built on total
// push/pop counts (addresses = totals mod depth) is compared every cycle,
// and literal expectations pin the key scenarios.
module tb_fifoctl_s1_dyn;

    localparam int DEP  [2] = '{4, 5};
    localparam int MODE [2] = '{0, 1};
    localparam logic [7:0] VEC [12] = '{
        8'b01_000_000, 8'b01_111_000, 8'b11_010_101, 8'b01_010_111,
        8'b01_000_100, 8'b01_011_010, 8'b01_000_110, 8'b11_001_001,
        8'b10_001_011, 8'b10_100_000, 8'b10_101_101, 8'b00_010_010
    };

    logic       clk;
    logic       rst_n;
    logic       diag_n;
    logic       push_req_n;
    logic       pop_req_n;
    logic [2:0] ae_level;
    logic [2:0] af_level;

    int n_tests;
    int n_fail;

    int m_push [2];
    int m_pop  [2];
    bit m_err  [2];
    int m_ae   [2];
    int m_af   [2];

    fifoctl_s1_dyn_if #(.DEPTH(4)) if4 ();
    fifoctl_s1_dyn_if #(.DEPTH(5)) if5 ();

    assign if4.push_req_n = push_req_n;
    assign if4.pop_req_n  = pop_req_n;
    assign if4.ae_level   = ae_level;
    assign if4.af_level   = af_level;
    assign if5.push_req_n = push_req_n;
    assign if5.pop_req_n  = pop_req_n;
    assign if5.ae_level   = ae_level;
    assign if5.af_level   = af_level;

    fifoctl_s1_dyn #(.DEPTH(4), .ERR_MODE(0)) u4 (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef FIFOCTL_S1_DYN_DIAG_EN
        .diag_n (diag_n),
`endif
        .bus    (if4.slave)
    );

    fifoctl_s1_dyn #(.DEPTH(5), .ERR_MODE(1)) u5 (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef FIFOCTL_S1_DYN_DIAG_EN
        .diag_n (diag_n),
`endif
        .bus    (if5.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    function automatic int mcnt(input int i);
        return m_push[i] - m_pop[i];
    endfunction

    function automatic bit mpush_ok(input int i);
        return !push_req_n && ((mcnt(i) != DEP[i]) || !pop_req_n) && diag_n;
    endfunction

    function automatic bit mpop_ok(input int i);
        return !pop_req_n && (mcnt(i) != 0) && diag_n;
    endfunction

    function automatic bit mevent(input int i);
        return (!push_req_n && (mcnt(i) == DEP[i]) && pop_req_n) || (!pop_req_n && (mcnt(i) == 0));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || !diag_n) begin
                m_push[i] <= 0;
                m_pop[i]  <= 0;
                m_err[i]  <= 1'b0;
            end else begin
                m_push[i] <= m_push[i] + int'(mpush_ok(i));
                m_pop[i]  <= m_pop[i] + int'(mpop_ok(i));
                m_err[i]  <= (MODE[i] == 1) ? mevent(i) : (m_err[i] | mevent(i));
            end
            m_ae[i] <= 32'(ae_level);
            m_af[i] <= 32'(af_level);
        end
    end

    // ---------------- checking ----------------
    task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b, expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int i, input logic we_n, input logic [31:0] wa,
                              input logic [31:0] ra, input logic [31:0] wc,
                              input logic e, input logic ae, input logic hf,
                              input logic af, input logic f, input logic err);
        int c;
        int thr;
        c   = mcnt(i);
        thr = DEP[i] - m_af[i];
        if (thr < 0) thr = 0;
        chkb($sformatf("d%0d_we_n", DEP[i]), we_n, !mpush_ok(i));
        chkv($sformatf("d%0d_wr_addr", DEP[i]), wa, m_push[i] % DEP[i]);
        chkv($sformatf("d%0d_rd_addr", DEP[i]), ra, m_pop[i] % DEP[i]);
        chkv($sformatf("d%0d_word_count", DEP[i]), wc, c);
        chkb($sformatf("d%0d_empty", DEP[i]), e, c == 0);
        chkb($sformatf("d%0d_almost_empty", DEP[i]), ae, c <= m_ae[i]);
        chkb($sformatf("d%0d_half_full", DEP[i]), hf, c >= (DEP[i] + 1) / 2);
        chkb($sformatf("d%0d_almost_full", DEP[i]), af, c >= thr);
        chkb($sformatf("d%0d_full", DEP[i]), f, c == DEP[i]);
        chkb($sformatf("d%0d_error", DEP[i]), err, m_err[i]);
    endtask

    always @(negedge clk) begin
        check_inst(0, if4.we_n, 32'(if4.wr_addr), 32'(if4.rd_addr), 32'(if4.word_count),
                   if4.empty, if4.almost_empty, if4.half_full, if4.almost_full, if4.full, if4.error);
        check_inst(1, if5.we_n, 32'(if5.wr_addr), 32'(if5.rd_addr), 32'(if5.word_count),
                   if5.empty, if5.almost_empty, if5.half_full, if5.almost_full, if5.full, if5.error);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic push, input logic pop);
        push_req_n = !push;
        pop_req_n  = !pop;
        @(posedge clk);
        #1;
        push_req_n = 1'b1;
        pop_req_n  = 1'b1;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        push_req_n = 1'b1;
        pop_req_n  = 1'b1;
        ae_level   = 3'd1;
        af_level   = 3'd1;
        diag_n     = 1'b1;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkb("rst_empty", if4.empty, 1'b1);
        chkb("rst_almost_empty", if4.almost_empty, 1'b1);
        chkb("rst_almost_full", if4.almost_full, 1'b0);
        chkv("rst_count", 32'(if4.word_count), 0);
        chkb("rst_full", if5.full, 1'b0);
        rst_n = 1'b1;

        // four pushes into the depth-4 FIFO
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0);
            chkv("fill_wr_addr", 32'(if4.wr_addr), k % 4);
            chkv("fill_count", 32'(if4.word_count), k);
            chkb("fill_almost_full", if4.almost_full, k >= 3);
        end
        chkb("fill_full", if4.full, 1'b1);

        // push and pop together while full
        push_req_n = 1'b0;
        pop_req_n  = 1'b0;
        #2;
        chkb("full_pp_we_n", if4.we_n, 1'b0);
        @(posedge clk);
        #1;
        push_req_n = 1'b1;
        pop_req_n  = 1'b1;
        chkv("full_pp_count", 32'(if4.word_count), 4);
        chkv("full_pp_wr_addr", 32'(if4.wr_addr), 1);
        chkv("full_pp_rd_addr", 32'(if4.rd_addr), 1);
        chkb("full_pp_error", if4.error, 1'b0);

        // drain, then push and pop together while empty
        repeat (4) step(1'b0, 1'b1);
        chkb("drain_empty", if4.empty, 1'b1);
        step(1'b1, 1'b1);
        chkv("empty_pp_count", 32'(if4.word_count), 1);
        chkb("underflow_sticky_set", if4.error, 1'b1);
        chkb("underflow_pulse_set", if5.error, 1'b1);
        step(1'b0, 1'b0);
        chkb("underflow_sticky_hold", if4.error, 1'b1);
        chkb("underflow_pulse_clear", if5.error, 1'b0);

        // depth-5 wrap with paired traffic
        repeat (7) begin
            step(1'b1, 1'b1);
            chkb("wrap_wr_in_range", if5.wr_addr < 3'd5, 1'b1);
            chkb("wrap_rd_in_range", if5.rd_addr < 3'd5, 1'b1);
        end
        chkv("wrap_wr_addr", 32'(if5.wr_addr), 3);
        chkv("wrap_rd_addr", 32'(if5.rd_addr), 2);
        step(1'b1, 1'b0);
        chkb("half_full_at2", if5.half_full, 1'b0);
        step(1'b1, 1'b0);
        chkb("half_full_at3", if5.half_full, 1'b1);

        // asynchronous reset mid-burst at count 3
        push_req_n = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chkv("async_rst_count", 32'(if4.word_count), 0);
        chkv("async_rst_wr_addr", 32'(if4.wr_addr), 0);
        chkv("async_rst_rd_addr", 32'(if5.rd_addr), 0);
        chkb("async_rst_empty", if4.empty, 1'b1);
        chkb("async_rst_half_full", if5.half_full, 1'b0);
        chkb("async_rst_error", if4.error, 1'b0);
        push_req_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // almost_empty threshold change at count 2
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chkb("ae_before", if4.almost_empty, 1'b0);
        ae_level = 3'd3;
        #2;
        chkb("ae_same_cycle", if4.almost_empty, 1'b0);
        @(posedge clk);
        #1;
        chkb("ae_next_edge", if4.almost_empty, 1'b1);

        // overflow
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chkv("overflow_count", 32'(if4.word_count), 4);
        chkb("overflow_sticky", if4.error, 1'b1);
        chkb("overflow_d5_full", if5.full, 1'b1);
        chkb("overflow_d5_quiet", if5.error, 1'b0);
        step(1'b1, 1'b0);
        chkb("overflow_pulse_set", if5.error, 1'b1);
        step(1'b0, 1'b0);
        chkb("overflow_pulse_clear", if5.error, 1'b0);

        // directed vectors with varying thresholds (saturation included)
        for (int k = 0; k < 12; k++) begin
            ae_level = VEC[k][5:3];
            af_level = VEC[k][2:0];
            step(VEC[k][7], VEC[k][6]);
        end
        ae_level = 3'd1;
        af_level = 3'd1;
        step(1'b0, 1'b0);

`ifdef FIFOCTL_S1_DYN_DIAG_EN
        // synchronous diagnostic clear overrides a push
        step(1'b1, 1'b0);
        push_req_n = 1'b0;
        diag_n     = 1'b0;
        #2;
        chkb("diag_we_n", if4.we_n, 1'b1);
        @(posedge clk);
        #1;
        diag_n     = 1'b1;
        push_req_n = 1'b1;
        chkv("diag_count", 32'(if4.word_count), 0);
        chkv("diag_wr_addr", 32'(if5.wr_addr), 0);
        chkb("diag_empty", if4.empty, 1'b1);
        chkb("diag_error", if4.error, 1'b0);
        step(1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
